// File: rtl/dpe_pkg.sv
// Shared types and constants for the dot-product engine operand loader.
// The optional WAIT watchdog is enabled by defining DPE_LOADER_TIMEOUT_EN.
package dpe_pkg;

    localparam int LANES_DEFAULT   = 64;
    localparam int W_WORDS_DEFAULT = 32;

    localparam logic [2:0] DT_INT8 = 3'd2;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_LOAD_X = 3'd1,
        ST_LOAD_W = 3'd2,
        ST_START  = 3'd3,
        ST_WAIT   = 3'd4
    } dpe_state_e;

    // Clamp a requested x length to the number of lanes actually present.
    function automatic logic [6:0] sat_x_len(input logic [6:0] len, input logic [6:0] max_len);
        return (len > max_len) ? max_len : len;
    endfunction

endpackage

// File: rtl/dpe_lane_decoder.sv
// Lane index to one-hot write-enable decoder for the x-vector BRAM lanes.
module dpe_lane_decoder
    import dpe_pkg::*;
#(
    parameter int LANES = LANES_DEFAULT,
    parameter int IDX_W = 6
) (
    input  logic             en,
    input  logic [IDX_W-1:0] idx,
    output logic [LANES-1:0] onehot
);

    generate
        for (genvar gi = 0; gi < LANES; gi++) begin : g_lane
            assign onehot[gi] = en && (idx == IDX_W'(gi));
        end
    endgenerate

endmodule

// File: rtl/dpe_operand_loader.sv
// Streams x elements into the engine's lane BRAMs and weight words to the engine,
// then starts the engine and waits for completion. Define DPE_LOADER_TIMEOUT_EN for a WAIT watchdog.
module dpe_operand_loader
    import dpe_pkg::*;
#(
    parameter int LANES    = LANES_DEFAULT,
    parameter int W_WORDS  = W_WORDS_DEFAULT,
    parameter int WD_LIMIT = 1024
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             go,
    input  logic [6:0]       cfg_x_len,
    input  logic [3:0]       cfg_x_addr,
    input  logic [2:0]       cfg_data_type,
    input  logic             x_valid,
    output logic             x_ready,
    input  logic [31:0]      x_data,
    input  logic             w_valid,
    output logic             w_ready,
    input  logic [15:0]      w_data,
    output logic [LANES-1:0] x_wr_en,
    output logic [31:0]      x_wr_data,
    output logic [3:0]       x_wr_addr,
    output logic [15:0]      weight_element,
    output logic [2:0]       data_type,
    output logic             eng_start,
    input  logic             eng_done,
    output logic             busy,
    output logic             row_done,
    output logic             err
);

    localparam int LANE_W = (LANES > 1) ? $clog2(LANES) : 1;
    localparam int WCNT_W = $clog2(W_WORDS + 1);
    localparam logic [6:0]        LEN_MAX = 7'(LANES);
    localparam logic [WCNT_W-1:0] W_LAST  = WCNT_W'(W_WORDS - 1);

    dpe_state_e        state_q, state_d;
    logic [6:0]        len_q, len_d;
    logic [3:0]        addr_q, addr_d;
    logic [2:0]        dt_q, dt_d;
    logic [6:0]        xcnt_q, xcnt_d;
    logic [WCNT_W-1:0] wcnt_q, wcnt_d;
    logic [6:0]        go_len;

    logic              x_ready_c, w_ready_c, eng_start_c, row_done_d;
    logic              x_fire, w_fire, wd_expired;
    logic [LANES-1:0]  lane_onehot;

    logic [LANES-1:0]  x_wr_en_q;
    logic [31:0]       x_wr_data_q;
    logic [3:0]        x_wr_addr_q;
    logic [15:0]       weight_q;
    logic              row_done_q;
    logic              err_c;

    assign go_len = sat_x_len(cfg_x_len, LEN_MAX);
    assign x_fire = x_ready_c && x_valid;
    assign w_fire = w_ready_c && w_valid;

    dpe_lane_decoder #(
        .LANES (LANES),
        .IDX_W (LANE_W)
    ) u_lane_decoder (
        .en     (x_fire),
        .idx    (xcnt_q[LANE_W-1:0]),
        .onehot (lane_onehot)
    );

`ifdef DPE_LOADER_TIMEOUT_EN
    localparam int WD_W = $clog2(WD_LIMIT + 1);
    localparam logic [WD_W-1:0] WD_LAST = WD_W'(WD_LIMIT - 1);

    logic [WD_W-1:0] wd_q, wd_d;
    logic            err_q;

    // Counts cycles spent in WAIT; cleared whenever the FSM is elsewhere.
    assign wd_d       = (state_q == ST_WAIT) ? wd_q + 1'b1 : '0;
    assign wd_expired = (state_q == ST_WAIT) && !eng_done && (wd_q == WD_LAST);

    always_ff @(posedge clk) begin
        if (rst) begin
            wd_q  <= '0;
            err_q <= 1'b0;
        end else begin
            wd_q  <= wd_d;
            err_q <= wd_expired;
        end
    end

    assign err_c = err_q;
`else
    logic unused_wd_limit;

    assign unused_wd_limit = (WD_LIMIT != 0);
    assign wd_expired      = 1'b0;
    assign err_c           = 1'b0;
`endif

    always_comb begin
        state_d     = state_q;
        len_d       = len_q;
        addr_d      = addr_q;
        dt_d        = dt_q;
        xcnt_d      = xcnt_q;
        wcnt_d      = wcnt_q;
        x_ready_c   = 1'b0;
        w_ready_c   = 1'b0;
        eng_start_c = 1'b0;
        row_done_d  = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (go) begin
                    len_d   = go_len;
                    addr_d  = cfg_x_addr;
                    dt_d    = cfg_data_type;
                    xcnt_d  = '0;
                    wcnt_d  = '0;
                    // A zero length keeps the x vector already resident in the lanes.
                    state_d = (go_len == 7'd0) ? ST_LOAD_W : ST_LOAD_X;
                end
            end
            ST_LOAD_X: begin
                x_ready_c = 1'b1;
                if (x_valid) begin
                    xcnt_d = xcnt_q + 7'd1;
                    if (xcnt_q == len_q - 7'd1) begin
                        state_d = ST_LOAD_W;
                    end
                end
            end
            ST_LOAD_W: begin
                w_ready_c = 1'b1;
                if (w_valid) begin
                    wcnt_d = wcnt_q + 1'b1;
                    if (wcnt_q == W_LAST) begin
                        state_d = ST_START;
                    end
                end
            end
            ST_START: begin
                eng_start_c = 1'b1;
                state_d     = ST_WAIT;
            end
            ST_WAIT: begin
                if (eng_done) begin
                    row_done_d = 1'b1;
                    state_d    = ST_IDLE;
                end else if (wd_expired) begin
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= ST_IDLE;
            len_q       <= '0;
            addr_q      <= '0;
            dt_q        <= '0;
            xcnt_q      <= '0;
            wcnt_q      <= '0;
            x_wr_en_q   <= '0;
            x_wr_data_q <= '0;
            x_wr_addr_q <= '0;
            weight_q    <= '0;
            row_done_q  <= 1'b0;
        end else begin
            state_q    <= state_d;
            len_q      <= len_d;
            addr_q     <= addr_d;
            dt_q       <= dt_d;
            xcnt_q     <= xcnt_d;
            wcnt_q     <= wcnt_d;
            x_wr_en_q  <= lane_onehot;
            row_done_q <= row_done_d;
            if (x_fire) begin
                x_wr_data_q <= x_data;
                x_wr_addr_q <= addr_q;
            end
            if (w_fire) begin
                weight_q <= w_data;
            end
        end
    end

    // Outputs are forced low for the whole time reset is held, even mid-row.
    assign x_ready        = !rst && x_ready_c;
    assign w_ready        = !rst && w_ready_c;
    assign eng_start      = !rst && eng_start_c;
    assign busy           = !rst && (state_q != ST_IDLE);
    assign row_done       = !rst && row_done_q;
    assign err            = !rst && err_c;
    assign x_wr_en        = rst ? '0 : x_wr_en_q;
    assign x_wr_data      = rst ? '0 : x_wr_data_q;
    assign x_wr_addr      = rst ? '0 : x_wr_addr_q;
    assign weight_element = rst ? '0 : weight_q;
    assign data_type      = rst ? '0 : dt_q;

endmodule

// File: tb/tb_dpe_operand_loader.sv
// Directed bench for dpe_operand_loader; the watchdog row runs when DPE_LOADER_TIMEOUT_EN is defined.
module tb_dpe_operand_loader;
    import dpe_pkg::*;

    localparam int LANES   = 64;
    localparam int W_WORDS = 32;

    logic             clk;
    logic             rst;
    logic             go;
    logic [6:0]       cfg_x_len;
    logic [3:0]       cfg_x_addr;
    logic [2:0]       cfg_data_type;
    logic             x_valid;
    logic             x_ready;
    logic [31:0]      x_data;
    logic             w_valid;
    logic             w_ready;
    logic [15:0]      w_data;
    logic [LANES-1:0] x_wr_en;
    logic [31:0]      x_wr_data;
    logic [3:0]       x_wr_addr;
    logic [15:0]      weight_element;
    logic [2:0]       data_type;
    logic             eng_start;
    logic             eng_done;
    logic             busy;
    logic             row_done;
    logic             err;

    int vectors     = 0;
    int miscompares = 0;
    int hs;
    logic [63:0] one = 64'd1;
    logic [63:0] exp_en;

    dpe_operand_loader #(
        .LANES    (LANES),
        .W_WORDS  (W_WORDS),
        .WD_LIMIT (16)
    ) dut (
        .clk            (clk),
        .rst            (rst),
        .go             (go),
        .cfg_x_len      (cfg_x_len),
        .cfg_x_addr     (cfg_x_addr),
        .cfg_data_type  (cfg_data_type),
        .x_valid        (x_valid),
        .x_ready        (x_ready),
        .x_data         (x_data),
        .w_valid        (w_valid),
        .w_ready        (w_ready),
        .w_data         (w_data),
        .x_wr_en        (x_wr_en),
        .x_wr_data      (x_wr_data),
        .x_wr_addr      (x_wr_addr),
        .weight_element (weight_element),
        .data_type      (data_type),
        .eng_start      (eng_start),
        .eng_done       (eng_done),
        .busy           (busy),
        .row_done       (row_done),
        .err            (err)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: observed no end of run, expected $finish");
        $fatal(1, "bench time limit");
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $display("FAIL %s: observed %h, expected %h", tag, obs, exp);
            $error("miscompare at %s", tag);
        end
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, ".x_ready"}, 64'(x_ready), 64'd0);
        chk({tag, ".w_ready"}, 64'(w_ready), 64'd0);
        chk({tag, ".x_wr_en"}, 64'(x_wr_en), 64'd0);
        chk({tag, ".x_wr_data"}, 64'(x_wr_data), 64'd0);
        chk({tag, ".x_wr_addr"}, 64'(x_wr_addr), 64'd0);
        chk({tag, ".weight"}, 64'(weight_element), 64'd0);
        chk({tag, ".data_type"}, 64'(data_type), 64'd0);
        chk({tag, ".eng_start"}, 64'(eng_start), 64'd0);
        chk({tag, ".busy"}, 64'(busy), 64'd0);
        chk({tag, ".row_done"}, 64'(row_done), 64'd0);
        chk({tag, ".err"}, 64'(err), 64'd0);
    endtask

    task automatic start_row(input logic [6:0] len, input logic [3:0] addr, input logic [2:0] dt);
        cfg_x_len     = len;
        cfg_x_addr    = addr;
        cfg_data_type = dt;
        go            = 1'b1;
        step();
        go = 1'b0;
        $display("row start: len=%0d addr=%0d dt=%0d", len, addr, dt);
        chk("start.busy", 64'(busy), 64'd1);
        chk("start.data_type", 64'(data_type), 64'(dt));
    endtask

    task automatic load_x(input int n, input logic [3:0] addr, input logic [31:0] base,
                          input logic [31:0] inc);
        logic [31:0] d;
        for (int i = 0; i < n; i++) begin
            d       = base + inc * 32'(i);
            x_valid = 1'b1;
            x_data  = d;
            step();
            exp_en = one << i;
            chk("load_x.en", 64'(x_wr_en), exp_en);
            chk("load_x.data", 64'(x_wr_data), 64'(d));
            chk("load_x.addr", 64'(x_wr_addr), 64'(addr));
        end
        x_valid = 1'b0;
    endtask

    // Feeds W_WORDS weights (optionally with a stall every other cycle) and steps into WAIT.
    task automatic feed_weights(input bit stall, input logic [15:0] base);
        int n = 0;
        int c = 0;
        logic [15:0] exp_w = '0;
        while (n < W_WORDS) begin
            w_valid = stall ? ((c % 2) == 0) : 1'b1;
            w_data  = base + 16'(n);
            step();
            if (w_valid) begin
                exp_w = base + 16'(n);
                n++;
            end
            if (n > 0) chk("weights.value", 64'(weight_element), 64'(exp_w));
            c++;
        end
        w_valid = 1'b0;
        chk("weights.eng_start", 64'(eng_start), 64'd1);
        chk("weights.w_ready_off", 64'(w_ready), 64'd0);
        step();
        chk("wait.eng_start_once", 64'(eng_start), 64'd0);
        chk("wait.busy", 64'(busy), 64'd1);
    endtask

    task automatic finish_row(input int idle_cycles);
        for (int i = 0; i < idle_cycles; i++) begin
            step();
            chk("wait.no_row_done", 64'(row_done), 64'd0);
        end
        eng_done = 1'b1;
        step();
        eng_done = 1'b0;
        chk("done.row_done", 64'(row_done), 64'd1);
        chk("done.busy", 64'(busy), 64'd0);
        step();
        chk("done.row_done_pulse", 64'(row_done), 64'd0);
        $display("row complete");
    endtask

    initial begin
        rst           = 1'b1;
        go            = 1'b0;
        cfg_x_len     = '0;
        cfg_x_addr    = '0;
        cfg_data_type = '0;
        x_valid       = 1'b0;
        x_data        = '0;
        w_valid       = 1'b0;
        w_data        = '0;
        eng_done      = 1'b0;
        step();
        step();
        chk_all_zero("reset");
        rst = 1'b0;
        step();
        chk_all_zero("post_reset");

        // Full 64-lane row of 1.0f, address 0.
        start_row(7'd64, 4'd0, DT_INT8);
        chk("s1.x_ready", 64'(x_ready), 64'd1);
        chk("s1.no_write_yet", 64'(x_wr_en), 64'd0);
        load_x(64, 4'd0, 32'h3F80_0000, 32'd0);
        chk("s1.x_ready_off", 64'(x_ready), 64'd0);
        chk("s1.w_ready", 64'(w_ready), 64'd1);
        feed_weights(1'b0, 16'h1000);
        chk("s1.x_wr_en_idle", 64'(x_wr_en), 64'd0);
        finish_row(3);

        // Over-length request saturates to 64 lanes.
        start_row(7'd100, 4'd7, 3'd1);
        load_x(64, 4'd7, 32'h0000_0100, 32'd1);
        chk("sat.x_ready_off", 64'(x_ready), 64'd0);
        chk("sat.w_ready", 64'(w_ready), 64'd1);
        feed_weights(1'b0, 16'h2000);
        finish_row(0);

        // Zero length reuses the resident x vector; weights stall every other cycle.
        start_row(7'd0, 4'd3, 3'd5);
        chk("s2.x_ready", 64'(x_ready), 64'd0);
        chk("s2.w_ready", 64'(w_ready), 64'd1);
        chk("s2.x_wr_en", 64'(x_wr_en), 64'd0);
        feed_weights(1'b1, 16'h3000);
        go        = 1'b1;
        cfg_x_len = 7'd5;
        step();
        go = 1'b0;
        chk("s6.go_in_wait.busy", 64'(busy), 64'd1);
        chk("s6.go_in_wait.x_ready", 64'(x_ready), 64'd0);
        chk("s6.go_in_wait.eng_start", 64'(eng_start), 64'd0);
        finish_row(0);
        eng_done = 1'b1;
        step();
        eng_done = 1'b0;
        chk("s6.done_in_idle.busy", 64'(busy), 64'd0);
        chk("s6.done_in_idle.row_done", 64'(row_done), 64'd0);

        // len=4 with x_valid toggling: writes land on lanes 0..3 only.
        start_row(7'd4, 4'd5, DT_INT8);
        hs = 0;
        for (int c = 0; c < 8; c++) begin
            x_valid = ((c % 2) == 0);
            x_data  = 32'hA5A5_0000 + 32'(c);
            step();
            if ((c % 2) == 0) begin
                exp_en = one << hs;
                hs++;
                chk("s3.data", 64'(x_wr_data), 64'(32'hA5A5_0000 + 32'(c)));
                chk("s3.addr", 64'(x_wr_addr), 64'd5);
            end else begin
                exp_en = 64'd0;
            end
            chk("s3.x_wr_en", 64'(x_wr_en), exp_en);
        end
        x_valid = 1'b0;
        chk("s3.w_ready", 64'(w_ready), 64'd1);
        feed_weights(1'b0, 16'h4000);
        finish_row(1);

        // Reset in LOAD_W after 10 weights, then a clean row.
        start_row(7'd2, 4'd6, 3'd3);
        load_x(2, 4'd6, 32'h1234_0000, 32'd1);
        for (int i = 0; i < 10; i++) begin
            w_valid = 1'b1;
            w_data  = 16'h0B00 + 16'(i);
            step();
        end
        w_valid = 1'b0;
        chk("s4.weight10", 64'(weight_element), 64'h0B09);
        rst = 1'b1;
        #1;
        chk("s4.in_reset.w_ready", 64'(w_ready), 64'd0);
        chk("s4.in_reset.busy", 64'(busy), 64'd0);
        step();
        chk_all_zero("s4.after_reset");
        rst      = 1'b0;
        eng_done = 1'b1;
        step();
        eng_done = 1'b0;
        chk("s4.done_at_release.busy", 64'(busy), 64'd0);
        chk("s4.done_at_release.row_done", 64'(row_done), 64'd0);
        start_row(7'd3, 4'd9, DT_INT8);
        load_x(3, 4'd9, 32'h4000_0000, 32'h10);
        feed_weights(1'b0, 16'h5000);
        finish_row(0);

        // WAIT with no eng_done.
        start_row(7'd0, 4'd0, DT_INT8);
        feed_weights(1'b0, 16'h6000);
`ifdef DPE_LOADER_TIMEOUT_EN
        for (int i = 1; i < 16; i++) begin
            step();
            chk("s5.err_early", 64'(err), 64'd0);
        end
        step();
        chk("s5.err", 64'(err), 64'd1);
        chk("s5.busy", 64'(busy), 64'd0);
        chk("s5.row_done", 64'(row_done), 64'd0);
        step();
        chk("s5.err_pulse", 64'(err), 64'd0);
        $display("row timed out");
`else
        for (int i = 0; i < 40; i++) begin
            step();
            chk("s5.err_off", 64'(err), 64'd0);
        end
        chk("s5.still_busy", 64'(busy), 64'd1);
        finish_row(0);
`endif

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/dpe_operand_loader.md
DPE_OPERAND_LOADER -- requirements
Module: dpe_operand_loader

Interface
REQ-001 SHALL have parameter LANES, default 64, number of x-vector BRAM lanes in the dot-product engine.
REQ-002 SHALL have parameter W_WORDS, default 32, number of 16-bit packed weight words per row.
REQ-003 SHALL have parameter WD_LIMIT, default 1024, maximum cycles in the WAIT state before a watchdog timeout (used only when DPE_LOADER_TIMEOUT_EN is defined).
REQ-004 Ports (name, direction, width, meaning); one clock, clk; reset rst is synchronous and active-high:
- clk  in  1  clock.
- rst  in  1  synchronous active-high reset.
- go  in  1  start one row operation; sampled only in IDLE.
- cfg_x_len  in  7  x elements to load, 0..64; 0 = reuse resident x vector.
- cfg_x_addr  in  4  BRAM word address for this row.
- cfg_data_type  in  3  engine data type; 3'd2 = INT8.
- x_valid / x_ready  in / out  1 / 1  FP32 x stream handshake.
- x_data  in  32  FP32 x element.
- w_valid / w_ready  in / out  1 / 1  weight stream handshake.
- w_data  in  16  packed weight word.
- x_wr_en  out  LANES  one-hot lane write enable to engine.
- x_wr_data  out  32  lane write data.
- x_wr_addr  out  4  lane write address.
- weight_element  out  16  weight word to engine.
- data_type  out  3  latched data type.
- eng_start  out  1  one-cycle engine start pulse.
- eng_done  in  1  engine completion.
- busy  out  1  high whenever state is not IDLE.
- row_done  out  1  one-cycle pulse on row completion.
- err  out  1  one-cycle watchdog-timeout pulse; tied 0 when the feature is compiled out.

Function
REQ-005 FSM states SHALL be IDLE, LOAD_X, LOAD_W, START, WAIT.
REQ-006 IDLE+go SHALL latch cfg_x_len, cfg_x_addr and cfg_data_type, then go to LOAD_X; if cfg_x_len==0, it SHALL go directly to LOAD_W. go outside IDLE SHALL be ignored.
REQ-007 LOAD_X: x_ready=1; each x handshake SHALL register x_wr_en=1<<lane, x_wr_data=x_data and x_wr_addr=latched addr one cycle later; lane counts 0..len-1; after the len-th handshake, the next state SHALL be LOAD_W.
REQ-008 x_wr_en SHALL be all-zero in every cycle that has no registered write; there SHALL be at most one lane bit set per cycle.
REQ-009 LOAD_W: w_ready=1; each handshake SHALL register weight_element=w_data; after W_WORDS handshakes, the next state SHALL be START. Stall cycles (valid=0) SHALL hold the counters.
REQ-010 START SHALL assert eng_start for exactly one cycle, then enter WAIT.
REQ-011 WAIT+eng_done SHALL pulse row_done for one cycle and return to IDLE; eng_done in any other state SHALL be ignored.
REQ-012 x_ready SHALL be 0 outside LOAD_X, and w_ready SHALL be 0 outside LOAD_W.
REQ-013 cfg_x_len>64 SHALL be saturated to 64.
REQ-014 Latency: go to first x_wr_en = 2 cycles with x_valid held high; last weight handshake to eng_start = 1 cycle.

Reset
REQ-015 rst SHALL force IDLE and clear all counters; every output SHALL be 0, including during reset mid-row, and data_type SHALL be 3'd0.
REQ-016 An eng_done arriving in the cycle reset deasserts SHALL be ignored.

Configuration
REQ-017 Defining DPE_LOADER_TIMEOUT_EN SHALL add a WAIT cycle counter; reaching WD_LIMIT without eng_done SHALL pulse err and return to IDLE without pulsing row_done.
REQ-018 Without DPE_LOADER_TIMEOUT_EN, WAIT SHALL wait indefinitely and err SHALL be constant 0.

Structure
REQ-019 Package dpe_pkg SHALL hold the FSM state enum, the data_type encodings (DT_INT8=3'd2) and the LANES/W_WORDS defaults.
REQ-020 One sub-module, dpe_lane_decoder (lane index to LANES-bit one-hot), SHALL be used.

Verification
REQ-021 The bench SHALL cover these scenarios:
- len=64, 64 x words of 32'h3F800000, 32 weight words -> x_wr_en walks 1<<0..1<<63, addr 0; one eng_start; row_done after eng_done.
- len=0 -> no x_wr_en activity; LOAD_W entered the cycle after go.
- x_valid toggling 1/0 with len=4 -> exactly 4 one-hot writes, lanes 0..3, in order.
- rst asserted in LOAD_W after 10 weights -> all outputs 0 next cycle; a new go completes a full row normally.
- DPE_LOADER_TIMEOUT_EN defined, WD_LIMIT=16, eng_done never asserted -> err pulses 16 cycles after entering WAIT; no row_done; busy=0.
- eng_done pulsed in IDLE, and go asserted in WAIT -> both ignored; no state change.
